cdc_sync_filter: RTL and testbench
==================================

CDC_SYNC_FILTER -- requirements
Module: cdc_sync_filter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent single-bit channels (1..32).
REQ-002 SHALL have parameter DEST_SYNC_FF, default 2, synchronizer stages per channel (2..10).
REQ-003 SHALL have parameter FILTER_CNT, default 4, consecutive stable cycles required before a change is accepted (1..65535; 1 = no filtering).
REQ-004 SHALL have parameter INIT_VAL, default 0, NUM_CH-bit reset value of sync flops and dest_out.
REQ-005 SHALL have port dest_clk  input  1  sole clock; all logic is in this domain.
REQ-006 SHALL have port dest_rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port src_in  input  NUM_CH  asynchronous level inputs, one per channel.
REQ-008 SHALL have port dest_out  output  NUM_CH  synchronized, filtered level.
REQ-009 SHALL have port dest_rise  output  NUM_CH  one-cycle pulse when dest_out goes 0->1.
REQ-010 SHALL have port dest_fall  output  NUM_CH  one-cycle pulse when dest_out goes 1->0.
REQ-011 SHALL have port dest_event_clr  input  NUM_CH  per-channel clear of the sticky event flag.
REQ-012 SHALL have port dest_event  output  NUM_CH  sticky flag, set by any accepted change.

Function
REQ-013 SHALL pass each src_in bit through a DEST_SYNC_FF-deep shift chain clocked by dest_clk; the last stage is "sync".
REQ-014 SHALL keep a per-channel counter, width clog2(FILTER_CNT+1), cleared on any cycle where sync == dest_out.
REQ-015 SHALL increment the counter on each cycle where sync != dest_out; when the incremented value reaches FILTER_CNT, dest_out SHALL take sync on that edge and the counter SHALL clear.
REQ-016 SHALL, for a src_in step stable from edge k, update dest_out at edge k+DEST_SYNC_FF+FILTER_CNT-1 (latency DEST_SYNC_FF+FILTER_CNT-1 cycles).
REQ-017 SHALL discard any sync glitch shorter than FILTER_CNT cycles: counter clears, dest_out unchanged, no pulse.
REQ-018 SHALL register dest_rise/dest_fall so they are high exactly in the cycle dest_out first shows the new value; never both high on one channel.
REQ-019 SHALL set dest_event[i] on the edge dest_out[i] changes and hold it until dest_event_clr[i] is sampled high.
REQ-020 SHALL give set priority over clear when a change and dest_event_clr coincide on one channel.
REQ-021 SHALL operate channels fully independently; no cross-channel coherency is provided or implied.

Reset
REQ-022 SHALL, while dest_rst is high, force sync chains and dest_out to INIT_VAL, counters to 0, dest_rise/dest_fall/dest_event to 0, asynchronously.
REQ-023 SHALL produce no pulse or event during reset or in the first cycle after release.
REQ-024 SHALL treat src_in != INIT_VAL at release as an ordinary change (edge after REQ-016 latency).
REQ-025 SHALL discard any in-flight filter count when reset asserts mid-operation.

Structure
REQ-026 SHALL place the clog2 function and parameter range limits in the shared cdc definitions include used by the dma pcores.
REQ-027 SHALL implement one channel as sub-module cdc_filter_ch, instantiated NUM_CH times by generate.
REQ-028 SHALL mark sync chain flops with ASYNC_REG and keep them free of logic between stages.
REQ-029 SHALL make the first sync stage the only logic sampling src_in.

Verification
REQ-030 SHALL cover step: NUM_CH=4, DEST_SYNC_FF=2, FILTER_CNT=4, src_in[0] 0->1 stable -> dest_out[0] rises 5 cycles later, dest_rise[0] one cycle, dest_event[0]=1.
REQ-031 SHALL cover glitch: src_in[1] high 3 cycles then low, FILTER_CNT=4 -> dest_out[1] stays 0, no pulse, no event.
REQ-032 SHALL cover clear collision: dest_event_clr[2]=1 on the same edge dest_out[2] falls -> dest_event[2] remains 1; clear next cycle -> 0.
REQ-033 SHALL cover reset: INIT_VAL=4'b1111, src_in=0 at release -> no pulse cycle 1; dest_fall on all 4 channels at latency.
REQ-034 SHALL cover mid-count reset: dest_rst pulsed while counter=3 -> dest_out=INIT_VAL, full latency restarts.
REQ-035 SHALL cover FILTER_CNT=1, DEST_SYNC_FF=3: 1-cycle-wide sync pulse -> propagates; dest_rise then dest_fall on consecutive cycles.

Source files
------------

// File: rtl/cdc_sync_filter_pkg.sv
// Shared CDC definitions: parameter limits, the ceiling-log2 helper and the
// per-channel status record passed from each channel to the top.
package cdc_sync_filter_pkg;

  localparam int NUM_CH_MIN     = 1;
  localparam int NUM_CH_MAX     = 32;
  localparam int SYNC_FF_MIN    = 2;
  localparam int SYNC_FF_MAX    = 10;
  localparam int FILTER_CNT_MIN = 1;
  localparam int FILTER_CNT_MAX = 65535;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic event_flag;
  } ch_status_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic bit params_ok(input int num_ch, input int sync_ff, input int filter_cnt);
    return (num_ch >= NUM_CH_MIN) && (num_ch <= NUM_CH_MAX) &&
           (sync_ff >= SYNC_FF_MIN) && (sync_ff <= SYNC_FF_MAX) &&
           (filter_cnt >= FILTER_CNT_MIN) && (filter_cnt <= FILTER_CNT_MAX);
  endfunction

endpackage

// File: rtl/cdc_filter_ch.sv
// One channel: a multi-flop synchronizer followed by a stability filter that
// only accepts a new level after FILTER_CNT consecutive differing cycles.
module cdc_filter_ch
  import cdc_sync_filter_pkg::*;
#(
  parameter int   DEST_SYNC_FF = 2,
  parameter int   FILTER_CNT   = 4,
  parameter logic INIT_BIT     = 1'b0
) (
  input  logic       dest_clk,
  input  logic       dest_rst,
  input  logic       src_i,
  input  logic       event_clr_i,
  output ch_status_t status_o
);

  localparam int CNT_W = clog2(FILTER_CNT + 1);

  // Plain shift chain: the first flop is the only sampler of src_i, with no
  // logic between stages so the tools can keep the flops adjacent.
  (* ASYNC_REG = "TRUE" *) logic [DEST_SYNC_FF-1:0] sync_q;

  logic             sync;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             event_q, event_d;
  logic             differ;
  logic             accept;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) begin
      sync_q <= {DEST_SYNC_FF{INIT_BIT}};
    end else begin
      sync_q <= {sync_q[DEST_SYNC_FF-2:0], src_i};
    end
  end

  assign sync    = sync_q[DEST_SYNC_FF-1];
  assign differ  = (sync != level_q);
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign accept  = differ && (cnt_inc == CNT_W'(FILTER_CNT));

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    event_d = event_q & ~event_clr_i;
    if (accept) begin
      level_d = sync;
      rise_d  = sync;
      fall_d  = ~sync;
      event_d = 1'b1;
    end else if (differ) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) begin
      cnt_q   <= '0;
      level_q <= INIT_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      event_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
    end
  end

  assign status_o.level      = level_q;
  assign status_o.rise       = rise_q;
  assign status_o.fall       = fall_q;
  assign status_o.event_flag = event_q;

endmodule

// File: rtl/cdc_sync_filter.sv
// Bank of NUM_CH independent synchronize-and-filter channels in the dest_clk
// domain, with edge pulses and sticky per-channel change flags.
module cdc_sync_filter
  import cdc_sync_filter_pkg::*;
#(
  parameter int                NUM_CH       = 4,
  parameter int                DEST_SYNC_FF = 2,
  parameter int                FILTER_CNT   = 4,
  parameter logic [NUM_CH-1:0] INIT_VAL     = '0
) (
  input  logic              dest_clk,
  input  logic              dest_rst,
  input  logic [NUM_CH-1:0] src_in,
  input  logic [NUM_CH-1:0] dest_event_clr,
  output logic [NUM_CH-1:0] dest_out,
  output logic [NUM_CH-1:0] dest_rise,
  output logic [NUM_CH-1:0] dest_fall,
  output logic [NUM_CH-1:0] dest_event
);

  if (!params_ok(NUM_CH, DEST_SYNC_FF, FILTER_CNT)) begin : g_param_err
    $error("cdc_sync_filter: parameter out of range");
  end

  ch_status_t status [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cdc_filter_ch #(
      .DEST_SYNC_FF (DEST_SYNC_FF),
      .FILTER_CNT   (FILTER_CNT),
      .INIT_BIT     (INIT_VAL[i])
    ) u_ch (
      .dest_clk    (dest_clk),
      .dest_rst    (dest_rst),
      .src_i       (src_in[i]),
      .event_clr_i (dest_event_clr[i]),
      .status_o    (status[i])
    );

    assign dest_out[i]   = status[i].level;
    assign dest_rise[i]  = status[i].rise;
    assign dest_fall[i]  = status[i].fall;
    assign dest_event[i] = status[i].event_flag;
  end

endmodule

// File: tb/tb_cdc_sync_filter.sv
// Directed bench for cdc_sync_filter: three configurations share one clock
// and reset; expected values are hand-derived latencies.
module tb_cdc_sync_filter;

  logic clk;
  logic rst;

  // A: 4 ch, 2 stages, filter 4, init 0
  logic [3:0] a_src, a_clr, a_out, a_rise, a_fall, a_evt;
  // B: 4 ch, 2 stages, filter 4, init all ones
  logic [3:0] b_src, b_clr, b_out, b_rise, b_fall, b_evt;
  // C: 1 ch, 3 stages, no filtering
  logic [0:0] c_src, c_clr, c_out, c_rise, c_fall, c_evt;

  int n_vec;
  int n_err;

  cdc_sync_filter #(.NUM_CH(4), .DEST_SYNC_FF(2), .FILTER_CNT(4), .INIT_VAL(4'b0000)) u_a (
    .dest_clk(clk), .dest_rst(rst), .src_in(a_src), .dest_event_clr(a_clr),
    .dest_out(a_out), .dest_rise(a_rise), .dest_fall(a_fall), .dest_event(a_evt));

  cdc_sync_filter #(.NUM_CH(4), .DEST_SYNC_FF(2), .FILTER_CNT(4), .INIT_VAL(4'b1111)) u_b (
    .dest_clk(clk), .dest_rst(rst), .src_in(b_src), .dest_event_clr(b_clr),
    .dest_out(b_out), .dest_rise(b_rise), .dest_fall(b_fall), .dest_event(b_evt));

  cdc_sync_filter #(.NUM_CH(1), .DEST_SYNC_FF(3), .FILTER_CNT(1), .INIT_VAL(1'b0)) u_c (
    .dest_clk(clk), .dest_rst(rst), .src_in(c_src), .dest_event_clr(c_clr),
    .dest_out(c_out), .dest_rise(c_rise), .dest_fall(c_fall), .dest_event(c_evt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    a_src = '0; a_clr = '0;
    b_src = '0; b_clr = '0;
    c_src = '0; c_clr = '0;

    repeat (2) tick();
    check("rst_a_out",   32'(a_out), 32'h0);
    check("rst_a_evt",   32'(a_evt), 32'h0);
    check("rst_a_pulse", 32'({a_rise, a_fall}), 32'h0);
    check("rst_b_out",   32'(b_out), 32'hF);
    check("rst_c_out",   32'(c_out), 32'h0);

    // Release: B sees src 0 vs init 1 as an ordinary change
    rst = 1'b0;
    tick();
    check("rel_b_pulse_cyc1", 32'({b_rise, b_fall, b_evt}), 32'h0);
    check("rel_a_pulse_cyc1", 32'({a_rise, a_fall, a_evt}), 32'h0);
    repeat (4) tick();
    check("rel_b_out_hold", 32'(b_out), 32'hF);
    tick();
    check("rel_b_out_fell", 32'(b_out),  32'h0);
    check("rel_b_fall",     32'(b_fall), 32'hF);
    check("rel_b_rise",     32'(b_rise), 32'h0);
    check("rel_b_evt",      32'(b_evt),  32'hF);
    tick();
    check("rel_b_fall_end", 32'(b_fall), 32'h0);

    // C: one-cycle pulse, 3 stages, no filter -> rise at +3, fall at +4
    c_src = 1'b1;
    tick();
    c_src = 1'b0;
    repeat (2) tick();
    check("c_out_before", 32'(c_out), 32'h0);
    tick();
    check("c_rise_out",  32'(c_out),  32'h1);
    check("c_rise",      32'(c_rise), 32'h1);
    check("c_rise_nofl", 32'(c_fall), 32'h0);
    tick();
    check("c_fall_out",  32'(c_out),  32'h0);
    check("c_fall_norr", 32'(c_rise), 32'h0);
    check("c_fall",      32'(c_fall), 32'h1);
    tick();
    check("c_fall_end",  32'(c_fall), 32'h0);

    // A ch0 step: dest_out rises 5 cycles after the first sampling edge
    a_src[0] = 1'b1;
    repeat (5) tick();
    check("step_out_early", 32'(a_out[0]), 32'h0);
    tick();
    check("step_out",  32'(a_out),  32'h1);
    check("step_rise", 32'(a_rise), 32'h1);
    check("step_fall", 32'(a_fall), 32'h0);
    check("step_evt",  32'(a_evt),  32'h1);
    tick();
    check("step_rise_end", 32'(a_rise[0]), 32'h0);
    check("step_evt_hold", 32'(a_evt[0]),  32'h1);

    // A ch1 glitch of 3 cycles is discarded
    a_src[1] = 1'b1;
    repeat (3) tick();
    a_src[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("glitch_c%0d", i),
            32'({a_out[1], a_rise[1], a_fall[1], a_evt[1]}), 32'h0);
    end

    // A ch2: set, clear, then clear colliding with a fall
    a_src[2] = 1'b1;
    repeat (6) tick();
    check("clr_set_out", 32'(a_out[2]), 32'h1);
    check("clr_set_evt", 32'(a_evt[2]), 32'h1);
    a_clr[2] = 1'b1;
    tick();
    a_clr[2] = 1'b0;
    check("clr_plain", 32'(a_evt[2]), 32'h0);
    check("clr_indep", 32'(a_evt[0]), 32'h1);
    a_src[2] = 1'b0;
    repeat (5) tick();
    check("clr_out_hold", 32'(a_out[2]), 32'h1);
    a_clr[2] = 1'b1;
    tick();
    check("coll_out",  32'(a_out[2]),  32'h0);
    check("coll_fall", 32'(a_fall[2]), 32'h1);
    check("coll_evt",  32'(a_evt[2]),  32'h1);
    tick();
    check("coll_clr_next", 32'(a_evt[2]), 32'h0);
    a_clr[2] = 1'b0;

    // A ch3: reset pulsed while the filter counter holds 3
    a_src[3] = 1'b1;
    repeat (5) tick();
    check("mid_out_pre", 32'(a_out[3]), 32'h0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_a_out", 32'(a_out), 32'h0);
    check("mid_rst_a_evt", 32'(a_evt), 32'h0);
    check("mid_rst_b_out", 32'(b_out), 32'hF);
    tick();
    rst = 1'b0;
    tick();
    check("mid_cyc1_pulse", 32'({a_rise, a_fall}), 32'h0);
    repeat (4) tick();
    check("mid_out_early", 32'(a_out), 32'h0);
    tick();
    check("mid_out",  32'(a_out),  32'b1001);
    check("mid_rise", 32'(a_rise), 32'b1001);
    check("mid_evt",  32'(a_evt),  32'b1001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
